// File: rtl/student_rr_mux.sv
// Registered N-channel arbitrating multiplexer with valid/ready handshakes on every input and the output.
// Arbitration is round-robin (mode=0) or fixed lowest-index priority (mode=1), feeding a single-entry output register.
module student_rr_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    logic             w_can_load;
    logic             w_found;
    logic             w_take;
    logic             w_hi_found;
    logic [SEL_W-1:0] w_hi_idx;
    logic [SEL_W-1:0] w_lo_idx;
    logic [SEL_W-1:0] w_fp_idx;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_data;

    assign w_can_load = !r_out_valid || out_ready;

    // Round-robin splits requesters into those above the pointer (searched first) and the
    // wrapped-around remainder; the descending loop leaves the lowest index of each group.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path can infer a latch.
        w_found    = 1'b0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_fp_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_found  = 1'b1;
                w_fp_idx = SEL_W'(i);
                if (SEL_W'(i) > r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SEL_W'(i);
                end else begin
                    w_lo_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        if (mode) begin
            w_idx = w_fp_idx;
        end else if (w_hi_found) begin
            w_idx = w_hi_idx;
        end else begin
            w_idx = w_lo_idx;
        end
    end

    assign w_take = w_can_load && w_found && !reset;

    always_comb begin
        w_data   = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == SEL_W'(i)) begin
                w_data      = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = w_take;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= SEL_W'(N - 1);
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_take) begin
                r_out_data  <= w_data;
                r_out_sel   <= w_idx;
                r_out_valid <= 1'b1;
                r_ptr       <= w_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_student_rr_mux.sv
// Self-checking bench for student_rr_mux: table-driven cycle vectors with a data/sel scoreboard,
// plus hand-written reset sequences.
module tb_student_rr_mux;

    localparam int WIDTH = 16;
    localparam int N     = 8;
    localparam int SEL_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               mode;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    logic [WIDTH-1:0]   chd [N];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chd[i];
    end

    student_rr_mux #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic         mode;
        logic [N-1:0] iv;
        logic         ordy;
        logic [N-1:0] exp_ready;
        logic         exp_ov;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
    } exp_t;

    vec_t             vecs[$];
    exp_t             sb[$];
    int               n_cmp  = 0;
    int               n_bad  = 0;
    logic [WIDTH-1:0] last_d = '0;
    logic [SEL_W-1:0] last_s = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SEL_W-1:0] oh2idx(input logic [N-1:0] oh);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = SEL_W'(i);
        return r;
    endfunction

    task automatic addv(input logic m, input logic [N-1:0] iv, input logic ordy,
                        input logic [N-1:0] er, input logic eov);
        vec_t v;
        v.mode = m; v.iv = iv; v.ordy = ordy; v.exp_ready = er; v.exp_ov = eov;
        vecs.push_back(v);
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic apply(input int k);
        vec_t             v;
        exp_t             e;
        logic [SEL_W-1:0] idx;
        v         = vecs[k];
        mode      = v.mode;
        in_valid  = v.iv;
        out_ready = v.ordy;
        #1;
        check($sformatf("vec%0d in_ready", k), in_ready, v.exp_ready);
        if (v.exp_ready != '0) begin
            idx = oh2idx(v.exp_ready);
            e.d = chd[idx];
            e.s = idx;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e      = sb.pop_front();
            last_d = e.d;
            last_s = e.s;
        end
        check($sformatf("vec%0d out_valid", k), out_valid, v.exp_ov);
        check($sformatf("vec%0d out_data", k), out_data, last_d);
        check($sformatf("vec%0d out_sel", k), out_sel, last_s);
        @(negedge clk);
    endtask

    task automatic run(input int lo, input int hi);
        for (int k = lo; k < hi; k++) apply(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int split1;
        int split2;

        // Round-robin fairness from reset: ptr starts at N-1 so channel 0 leads.
        for (int i = 0; i < N; i++) addv(1'b0, 8'hFF, 1'b1, 8'(1 << i), 1'b1);
        addv(1'b0, 8'hFF, 1'b1, 8'h01, 1'b1);
        // Fixed priority: ch2 beats ch5 until ch2 drops.
        addv(1'b1, 8'h24, 1'b1, 8'h04, 1'b1);
        addv(1'b1, 8'h24, 1'b1, 8'h04, 1'b1);
        addv(1'b1, 8'h24, 1'b1, 8'h04, 1'b1);
        addv(1'b1, 8'h20, 1'b1, 8'h20, 1'b1);
        split1 = vecs.size();
        // Load BEEF from ch6, backpressure 3 cycles, then release to ch0 (wrap past 7).
        addv(1'b0, 8'h40, 1'b1, 8'h40, 1'b1);
        addv(1'b0, 8'h0F, 1'b0, 8'h00, 1'b1);
        addv(1'b0, 8'h0F, 1'b0, 8'h00, 1'b1);
        addv(1'b0, 8'h0F, 1'b0, 8'h00, 1'b1);
        addv(1'b0, 8'h0F, 1'b1, 8'h01, 1'b1);
        // Drain, then confirm ptr held at 0 (next round-robin winner is ch1).
        addv(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        addv(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        addv(1'b0, 8'hFF, 1'b1, 8'h02, 1'b1);
        // Mode switch: fixed priority grants ch3, then round-robin wraps to ch0, then ch3.
        addv(1'b1, 8'h08, 1'b1, 8'h08, 1'b1);
        addv(1'b0, 8'h09, 1'b1, 8'h01, 1'b1);
        addv(1'b0, 8'h09, 1'b1, 8'h08, 1'b1);
        // Empty register loads even with out_ready low; then it holds.
        addv(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        addv(1'b0, 8'h04, 1'b0, 8'h04, 1'b1);
        addv(1'b0, 8'h04, 1'b0, 8'h00, 1'b1);
        split2 = vecs.size();
        addv(1'b0, 8'h01, 1'b1, 8'h01, 1'b1);

        for (int i = 0; i < N; i++) chd[i] = WIDTH'(16'h0100 + i);
        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;

        @(negedge clk);
        in_valid = '1;
        #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, 16'h0000);
        check("reset out_sel", out_sel, 3'd0);
        check("reset in_ready", in_ready, 8'h00);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = '0;

        run(0, split1);
        chd[6] = 16'hBEEF;
        run(split1, split2);

        // Asynchronous reset mid-cycle while a word is held.
        chd[0]    = 16'h1234;
        in_valid  = 8'h01;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset out_data", out_data, 16'h0000);
        check("midreset out_sel", out_sel, 3'd0);
        check("midreset in_ready", in_ready, 8'h00);
        @(negedge clk);
        reset  = 1'b0;
        last_d = '0;
        last_s = '0;
        sb.delete();
        run(split2, vecs.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/student_rr_mux.md
Name: student_rr_mux

Overview:
Parametrised successor to the combinational 16-bit multiplexers. It is a registered N-channel, WIDTH-bit arbitrating multiplexer with valid/ready handshakes on every input channel and on the output. It selects one requesting channel per transfer, using either round-robin or fixed-priority arbitration. It latches the chosen word into a single-entry output register and reports which channel supplied it. It sits between multiple producers and a single consumer, such as a shared bus or ALU operand port.

Parameters:
WIDTH, 16, data width of each channel in bits.
N, 8, number of input channels (legal range 2..8).
SEL_W, 3, width of the channel index; must satisfy 2**SEL_W >= N.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  input  N  per-channel request; bit i asserted = channel i offers a word.
in_ready  output  N  per-channel grant/accept; at most one bit high in any cycle.
out_data  output  WIDTH  registered selected word.
out_sel  output  SEL_W  registered index of the channel that supplied out_data.
out_valid  output  1  out_data/out_sel hold a valid word.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=N-1, so channel 0 has the highest priority first.
  - in_ready=0 while reset is high.
- Asserting reset mid-operation discards any held word. No partial state survives.
- can_load = !out_valid || out_ready. The output register may take a new word this cycle.
- Arbitration is combinational in the current cycle and considers only channels with in_valid set:
  - mode=0: the winner is the first requesting index found searching ptr+1, ptr+2, ... wrapping modulo N.
  - mode=1: the winner is the lowest requesting index; ptr is ignored for selection.
- in_ready[g]=1 only when can_load && in_valid[g] && g is the winner. All other in_ready bits are 0.
- in_ready never depends on in_ready itself. It may depend combinationally on in_valid, mode and out_ready.
- Input transfer on channel g happens when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= g. ptr updates in both modes, so switching to mode 0 resumes fairly.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready is held high.
- Output handshake:
  - While out_valid && !out_ready, out_data and out_sel hold stable and in_ready stays all-zero (backpressure).
  - If out_valid && out_ready and no input transfer occurs: out_valid <= 0 at the edge. out_data and out_sel keep their last value.
  - If out_valid && out_ready and an input transfer occurs in the same cycle, the register reloads with the new word and out_valid stays 1. No bubble.
- No requests: in_ready=0 and ptr holds.
- Changing mode takes effect on the next arbitration decision. It never alters the word already held.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.
- Channel indices >= N do not exist. in_valid bits never index beyond N-1, and out_sel never exceeds N-1.

Test Plan:
1. Reset: assert reset mid-cycle while out_valid=1 -> out_valid, out_data and out_sel read 0 immediately. After release, in_valid=8'h01 with ch0=16'h1234 -> in_ready=8'h01; next cycle out_data=16'h1234, out_sel=0, out_valid=1.
2. Round-robin fairness: mode=0, in_valid=8'hFF held, out_ready=1, ch i data=16'h0100+i -> out_sel sequence 0,1,...,7,0 on consecutive cycles. out_valid stays 1 with no bubbles.
3. Fixed priority: mode=1, in_valid=8'b0010_0100 held, out_ready=1 -> channel 2 is granted every cycle. Drop in_valid[2] -> channel 5 is granted the next cycle.
4. Backpressure: out_valid=1 with out_data=16'hBEEF, out_ready=0 for 3 cycles, in_valid=8'h0F -> in_ready=0 throughout and out_data holds 16'hBEEF. Raise out_ready -> same-cycle grant to the next round-robin channel and reload without a bubble.
5. Drain: single request accepted, then in_valid=0 and out_ready=1 -> out_valid falls to 0 one cycle after the output transfer, and ptr holds.
6. Mode switch and wrap: mode=1 grants ch3 (ptr=3), then switch to mode=0 with in_valid=8'b0000_1001 -> ch0 is granted, via wrap from ptr=3 past index 7.
